// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings, FSM states and op decode helpers for the mul/div unit
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } md_state_t;

  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/result handshake bundle between EX stage and mul/div unit
interface muldiv_if #(
  parameter int XLEN = 32
);

  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            cancel;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_hi;
  logic [XLEN-1:0] out_lo;
  logic            busy;

  modport master (
    output in_valid, op, a, b, cancel, out_ready,
    input  in_ready, out_valid, out_hi, out_lo, busy
  );

  modport slave (
    input  in_valid, op, a, b, cancel, out_ready,
    output in_ready, out_valid, out_hi, out_lo, busy
  );

endinterface

// File: rtl/muldiv_sign_fix.sv
// rtl/muldiv_sign_fix.sv - conditional two's-complement negate of a W-bit value
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 MULT/MULTU/DIV/DIVU returning {hi,lo}
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  muldiv_if.slave  bus
);

  localparam int CNT_W = $clog2(XLEN + 1);

  md_state_t         state, state_nxt;
  logic [1:0]        op_q;
  logic              neg_q, rem_neg_q;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc, acc_nxt;
  logic [XLEN-1:0]   opnd;
  logic [XLEN-1:0]   out_hi_q, out_lo_q;

  logic              accept, sgn_in, sa, sb, div_zero;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     sum, rem_sh, diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, res_hi, res_lo;

  assign accept   = bus.in_valid & bus.in_ready & ~bus.cancel;
  assign sgn_in   = md_is_signed(bus.op);
  assign sa       = sgn_in & bus.a[XLEN-1];
  assign sb       = sgn_in & bus.b[XLEN-1];
  assign div_zero = md_is_div(bus.op) && (bus.b == '0);

  muldiv_sign_fix #(.W(XLEN)) u_abs_a (.neg(sa), .din(bus.a), .dout(mag_a));
  muldiv_sign_fix #(.W(XLEN)) u_abs_b (.neg(sb), .din(bus.b), .dout(mag_b));

  // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sum     = '0;
    rem_sh  = '0;
    diff    = '0;
    acc_nxt = acc;
    if (md_is_div(op_q)) begin
      rem_sh = acc[2*XLEN-1:XLEN-1];
      diff   = rem_sh - {1'b0, opnd};
      if (!diff[XLEN])
        acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      acc_nxt = {sum, acc[XLEN-1:1]};
    end
  end

  muldiv_sign_fix #(.W(2*XLEN)) u_fix_prod (.neg(neg_q),     .din(acc_nxt),                   .dout(prod_fix));
  muldiv_sign_fix #(.W(XLEN))   u_fix_quot (.neg(neg_q),     .din(acc_nxt[XLEN-1:0]),         .dout(quot_fix));
  muldiv_sign_fix #(.W(XLEN))   u_fix_rem  (.neg(rem_neg_q), .din(acc_nxt[2*XLEN-1:XLEN]),    .dout(rem_fix));

  assign res_hi = md_is_div(op_q) ? rem_fix  : prod_fix[2*XLEN-1:XLEN];
  assign res_lo = md_is_div(op_q) ? quot_fix : prod_fix[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = div_zero ? DONE : CALC;
      CALC: begin
        if (bus.cancel)
          state_nxt = IDLE;
        else if (cnt == CNT_W'(1))
          state_nxt = DONE;
      end
      DONE: if (bus.cancel || bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      out_hi_q  <= '0;
      out_lo_q  <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_q      <= bus.op;
          neg_q     <= sa ^ sb;
          rem_neg_q <= sa;
          cnt       <= CNT_W'(XLEN);
          if (md_is_div(bus.op)) begin
            acc  <= {{XLEN{1'b0}}, mag_a};
            opnd <= mag_b;
            if (div_zero) begin
              out_hi_q <= bus.a;
              out_lo_q <= '1;
            end
          end else begin
            acc  <= {{XLEN{1'b0}}, mag_b};
            opnd <= mag_a;
          end
        end
        CALC: if (!bus.cancel) begin
          acc <= acc_nxt;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            out_hi_q <= res_hi;
            out_lo_q <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_hi    = out_hi_q;
  assign bus.out_lo    = out_lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit with directed vectors
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(XLEN)) bus();
  muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    int          t0;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (bus.out_valid && !prev_v && sb_q.size() > 0)
        check({sb_q[0].name, " latency"}, 64'(cyc - sb_q[0].t0), 64'(sb_q[0].lat));
      if (bus.out_valid && bus.out_ready && !bus.cancel) begin
        if (sb_q.size() == 0) begin
          check("unexpected result", {63'b0, bus.out_valid}, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check({e.name, " hi"}, bus.out_hi, e.hi);
          check({e.name, " lo"}, bus.out_lo, e.lo);
        end
      end
      prev_v = bus.out_valid;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input int lat,
                       input string name, input bit push);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) begin
      check({name, " in_ready wait"}, {63'b0, bus.in_ready}, 64'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    if (push) sb_q.push_back('{hi: hi, lo: lo, lat: lat, t0: cyc, name: name});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.op       = 2'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() > 0) begin
      check("drain timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] hi, input logic [31:0] lo, input int lat, input string name);
    issue(op, a, b, hi, lo, lat, name, 1'b1);
    drain();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " out_valid"}, {63'b0, bus.out_valid}, 64'd1);
  endtask

  initial begin
    int seen;
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.a         = '0;
    bus.b         = '0;
    bus.cancel    = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst in_ready",  {63'b0, bus.in_ready},  64'd0);
    check("rst out_valid", {63'b0, bus.out_valid}, 64'd0);
    check("rst busy",      {63'b0, bus.busy},      64'd0);
    check("rst out_hi",    bus.out_hi, 64'd0);
    check("rst out_lo",    bus.out_lo, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready after rst", {63'b0, bus.in_ready}, 64'd1);
    @(posedge clk); #1;

    run(MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33, "mult_neg");
    run(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, "multu_max");
    run(MD_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 33, "divu_7_2");
    run(MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, "div_neg");
    run(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, "div_min_m1");
    run(MD_DIV,   32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1,  "div_zero");
    run(MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, "div_pos_neg");
    run(MD_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 33, "div_neg_neg");
    run(MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33, "mult_min_sq");
    run(MD_MULT,  32'h00000006, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFD6, 33, "mult_pos_neg");
    run(MD_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 33, "divu_max_1");
    run(MD_DIVU,  32'h80000000, 32'h00000003, 32'h00000002, 32'h2AAAAAAA, 33, "divu_big_3");
    run(MD_MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000, 33, "multu_zero");
    run(MD_DIVU,  32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1,  "divu_zero");

    // result held under back-pressure
    bus.out_ready = 1'b0;
    issue(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33, "stall", 1'b1);
    wait_valid("stall");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall out_valid", {63'b0, bus.out_valid}, 64'd1);
      check("stall out_hi",    bus.out_hi, 64'd2);
      check("stall out_lo",    bus.out_lo, 64'd14);
      check("stall in_ready",  {63'b0, bus.in_ready}, 64'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drain();

    // cancel in the tenth CALC cycle
    issue(MD_MULT, 32'd5, 32'd6, 32'd0, 32'd0, 0, "cancel_calc", 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    check("cancel_calc in_ready", {63'b0, bus.in_ready}, 64'd1);
    check("cancel_calc busy",     {63'b0, bus.busy},     64'd0);
    seen = 0;
    repeat (40) begin @(negedge clk); seen |= int'(bus.out_valid); end
    check("cancel_calc no result", 64'(seen), 64'd0);
    @(posedge clk); #1;
    run(MD_MULT, 32'd5, 32'd6, 32'd0, 32'd30, 33, "after_cancel");

    // cancel alongside in_valid in IDLE blocks the request
    bus.in_valid = 1'b1;
    bus.op       = MD_MULT;
    bus.a        = 32'd3;
    bus.b        = 32'd3;
    bus.cancel   = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.cancel   = 1'b0;
    check("cancel_idle busy", {63'b0, bus.busy}, 64'd0);

    // cancel beats out_ready in DONE
    bus.out_ready = 1'b0;
    issue(MD_DIVU, 32'd9, 32'd3, 32'd0, 32'd0, 0, "cancel_done", 1'b0);
    wait_valid("cancel_done");
    bus.cancel    = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    check("cancel_done out_valid", {63'b0, bus.out_valid}, 64'd0);
    check("cancel_done busy",      {63'b0, bus.busy},      64'd0);

    // reset mid-operation
    issue(MD_DIV, 32'd50, 32'd5, 32'd0, 32'd0, 0, "rst_mid", 1'b0);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid busy", {63'b0, bus.busy}, 64'd0);
    seen = 0;
    repeat (40) begin @(negedge clk); seen |= int'(bus.out_valid); end
    check("rst_mid no result", 64'(seen), 64'd0);
    @(posedge clk); #1;
    run(MD_DIV, 32'hFFFFFFCE, 32'd5, 32'd0, 32'hFFFFFFF6, 33, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
